// File: rtl/dt_pkg.sv
// Shared types and constants for the display time-sharing arbiter.
// Digit/value widths, default hold time and the arbiter state encoding.
package dt_pkg;

    localparam int DIGIT_W      = 4;
    localparam int VAL_W        = 16;
    localparam int HOLD_CYC_DEF = 48_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } dt_state_e;

    // The hold counter needs at least one bit even when HOLD_CYC is 1.
    function automatic int cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/dt_rr_pick.sv
// Combinational round-robin picker: scans req starting after last_owner,
// ignoring bits set in excl, and returns the first set bit.
module rr_pick
    import dt_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    input  logic [N_REQ-1:0] excl,
    output logic             valid,
    output logic [IDX_W-1:0] win_idx,
    output logic [N_REQ-1:0] win_oh
);

    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] sel;
    int               idx;

    always_comb begin
        valid   = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        cand    = req & ~excl;
        sel     = '0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_owner) + k) % N_REQ;
            sel = IDX_W'(idx);
            if (!valid && cand[sel]) begin
                valid   = 1'b1;
                win_idx = sel;
                win_oh  = N_REQ'(1) << sel;
            end
        end
    end

endmodule

// File: rtl/dt_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum on-screen time;
// registers the owner's 16-bit value as four nibbles for dt_module.
module dt_arbiter
    import dt_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N_REQ-1:0]       req,
    input  logic [VAL_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]       grant,
    output logic [DIGIT_W-1:0]     num1,
    output logic [DIGIT_W-1:0]     num2,
    output logic [DIGIT_W-1:0]     num3,
    output logic [DIGIT_W-1:0]     num4,
    output logic                   busy,
    output dt_state_e              state_dbg
);

    localparam int               IDX_W      = $clog2(N_REQ);
    localparam int               CNT_W      = cnt_width(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_REQ - 1);

    // Handshake: req[i] is a level held by producer i for as long as it wants
    // the display; grant[i] rises one edge after it is picked and stays until
    // the owner drops req or the hold time expires with another req pending.

    dt_state_e        state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VAL_W-1:0] num_q, num_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] excl;
    logic [VAL_W-1:0] owner_val;
    logic [VAL_W-1:0] win_val;
    logic             owner_req;
    logic             do_switch;

    // In SHOW the current owner is excluded so a pick is always "someone else".
    assign excl      = (state_q == SHOW) ? grant_q : '0;
    assign owner_req = |(req & grant_q);

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_owner (last_q),
        .excl       (excl),
        .valid      (pick_valid),
        .win_idx    (pick_idx),
        .win_oh     (pick_oh)
    );

    always_comb begin
        owner_val = '0;
        win_val   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (last_q == IDX_W'(i))   owner_val = data[i*VAL_W +: VAL_W];
            if (pick_idx == IDX_W'(i)) win_val   = data[i*VAL_W +: VAL_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        do_switch = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) do_switch = 1'b1;
            end
            SHOW: begin
                if (!owner_req) begin
                    if (pick_valid) begin
                        do_switch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (cnt_q == '0) begin
                    if (pick_valid) begin
                        do_switch = 1'b1;
                    end else begin
                        cnt_d = CNT_RELOAD;
                        num_d = owner_val;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    num_d = owner_val;
                end
            end
            default: state_d = IDLE;
        endcase
        // A switch lands in one edge: no idle cycle, no blank frame.
        if (do_switch) begin
            state_d = SHOW;
            grant_d = pick_oh;
            last_d  = pick_idx;
            cnt_d   = CNT_RELOAD;
            num_d   = win_val;
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            num_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            busy_q  <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;
    assign num1      = num_q[3:0];
    assign num2      = num_q[7:4];
    assign num3      = num_q[11:8];
    assign num4      = num_q[15:12];

endmodule

// File: doc/dt_arbiter.md
# dt_arbiter

Time-sharing arbiter for the 4-digit seven-segment display. Up to N_REQ producers (counters, key handlers, status monitors) request the display. dt_arbiter grants one owner at a time with round-robin fairness and a guaranteed minimum on-screen time. It drives the four BCD/hex nibbles consumed by dt_module, which keeps the scan and segment decode.

## Interface
Parameters:
- N_REQ, 3: number of requesters, range 2..8.
- HOLD_CYC, 48_000_000: minimum ownership time in CLK cycles (1 s at 48 MHz); must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  system clock, 48 MHz.
- RST_N  in  1  asynchronous active-low reset.
- req  in  N_REQ  level request per producer; bit i belongs to producer i.
- data  in  16*N_REQ  producer i value in data[16*i+15:16*i]; nibble [3:0] goes to num1, [15:12] to num4.
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- num1, num2, num3, num4  out  4 each  digit values to dt_module.
- busy  out  1  high while any grant bit is set.

## Operation
- The FSM has two states: IDLE and SHOW. State, grant, num1..4, the hold counter and last_owner are all registered.
- Reset values: state=IDLE, grant=0, busy=0, num1..4=0, counter=0, last_owner=N_REQ-1. With these values, producer 0 wins the first arbitration.
- Round-robin pick: search req starting at index (last_owner+1) mod N_REQ and wrap around. The first set bit wins.
- IDLE:
  - With req≠0, on the next edge: grant=onehot(winner), last_owner=winner, counter=HOLD_CYC-1, num1..4=data[winner] slice, state=SHOW.
  - With req=0, grant stays 0 and num1..4 hold their last value. The display is frozen, not blanked.
- SHOW, each edge, first matching rule applies:
  1. req[owner]=0 (early release). If another req is set, switch to the RR winner, which excludes the owner. Otherwise go to IDLE with grant=0 and num frozen.
  2. counter=0 and another req is set: switch to the RR winner.
  3. counter=0 and only the owner requests: reload counter=HOLD_CYC-1, owner unchanged.
  4. Otherwise: counter decrements by 1 and num1..4 reload from data[owner], so the display tracks the owner's value live.
- Switch action: in a single edge, grant moves to the new one-hot, last_owner is updated, the counter reloads and num1..4 load the new owner's data. There is no idle gap and no blank frame.
- Requests arriving while another producer owns the display wait. No preemption happens before the counter expires.
- The counter is an unsigned binary down-counter of width $clog2(HOLD_CYC). It never underflows.
- With HOLD_CYC=1, the counter is always 0 and ownership can rotate every cycle.

## Timing
- Request to grant: req sampled high at edge t gives grant and num valid after edge t (one-cycle latency).
- Data to num: one cycle while the producer owns the display.
- Minimum ownership is HOLD_CYC cycles unless the owner drops req.
- busy equals the OR of the grant bits and is a registered output.
- RST_N assertion mid-SHOW forces reset values asynchronously, so the display immediately shows 0000. Release must be synchronized externally to CLK; the first arbitration occurs on the first edge after deassertion.
- Simultaneous events: owner drop at the expiry edge follows rule 1. Multiple new requests in IDLE resolve purely by RR order.

## Structure
- Shared package dt_pkg: DIGIT_W=4, VAL_W=16, default HOLD_CYC, and the state enum {IDLE, SHOW}.
- Sub-module rr_pick: purely combinational. Inputs are req, last_owner and an exclude mask. Outputs are a valid flag, the winner index and the winner one-hot. It is reused by both the IDLE and SHOW branches.
- dt_arbiter holds the FSM, counter, last_owner and the num registers. It instantiates rr_pick once.

## Test plan
Bench settings: HOLD_CYC=4, N_REQ=3.
1. Reset then req=3'b111: grant=001 for 4 cycles, then 010 for 4, then 100, then 001. num tracks data0=16'h1234 as num4..num1 = 1,2,3,4.
2. Single requester req=3'b010 held for 20 cycles: grant stays 010 throughout, counter reloads every 4 cycles, and busy stays 1.
3. Early release: producer 0 owns, req0 drops at cycle 2 with req2 high. grant goes to 100 on the next edge with no zero cycle, and num shows data2.
4. Release to idle: sole owner drops req, so grant=0 and busy=0. num keeps the last value 16'hBEEF until the next grant.
5. Live update: owner changes data 16'h0001 to 16'h0002. num1 follows exactly one cycle later.
6. RST_N pulsed low mid-SHOW, asynchronously between edges: grant=0 and num=0 immediately. After release with req=3'b100, grant=100 (it first wins over an empty field), and subsequent RR order restarts from 0.
